pga_spi_driver: RTL and testbench

Drives the front-end programmable-gain amplifier over its 3-wire SPI write port, sitting between the gain controller (`pga_code`/`set_pga`/`pga_ready` handshake) and the PGA pins. It accepts one 8-bit gain code per request, serialises a 16-bit command frame, and waits a settling interval. It then re-asserts ready. After reset it holds ready low for a power-up interval so the first gain set is never issued to an unpowered PGA.

---
 rtl/afe_pkg.sv | 14 +
 rtl/pga_tick_gen.sv | 38 +++
 rtl/pga_spi_driver.sv | 162 ++++++++++++++++
 tb/tb_pga_spi_driver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/afe_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | afe_pkg : widths and defaults shared by the gain controller and PGA link |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package afe_pkg;

  localparam int PGA_CODE_W  = 8;
  localparam int PGA_FRAME_W = 16;

  localparam logic [PGA_CODE_W-1:0] PGA_CMD_BYTE = 8'h00;

endpackage
`default_nettype wire

// File: rtl/pga_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pga_tick_gen : CLK_DIV divider, one-cycle tick at the end of each phase  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pga_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CNT_W = $clog2(CLK_DIV + 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick_o = (int'(cnt_q) == CLK_DIV - 1);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || tick_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pga_spi_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pga_spi_driver : 3-wire SPI writer for the PGA gain register             |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pga_spi_driver
  import afe_pkg::*;
#(
  parameter int                    CLK_DIV        = 4,
  parameter int                    STARTUP_CYCLES = 64,
  parameter int                    SETTLE_CYCLES  = 16,
  parameter logic [PGA_CODE_W-1:0] CMD_BYTE       = PGA_CMD_BYTE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PGA_CODE_W-1:0] pga_code_i,
  input  logic                  set_pga_i,
  output logic                  pga_ready_o,
  output logic [PGA_CODE_W-1:0] pga_code_q_o,
  output logic                  pga_cs_n_o,
  output logic                  pga_sclk_o,
  output logic                  pga_mosi_o
);

  localparam int WAIT_MAX = (STARTUP_CYCLES > SETTLE_CYCLES) ? STARTUP_CYCLES : SETTLE_CYCLES;
  localparam int WAIT_W   = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    ST_STARTUP = 3'd0,
    ST_IDLE    = 3'd1,
    ST_SETUP   = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_SETTLE  = 3'd4
  } state_e;

  state_e                   state_q,  state_d;
  logic [WAIT_W-1:0]        wait_q,   wait_d;
  logic [4:0]               bit_q,    bit_d;
  logic [PGA_FRAME_W-1:0]   frame_q,  frame_d;
  logic [PGA_CODE_W-1:0]    code_q,   code_d;
  logic                     ready_q,  ready_d;
  logic                     cs_n_q,   cs_n_d;
  logic                     sclk_q,   sclk_d;
  logic                     mosi_q,   mosi_d;
  logic                     w_accept;
  logic                     w_tick;

  pga_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk       (clk),
    .rst       (rst),
    .restart_i (w_accept),
    .tick_o    (w_tick)
  );

  always_comb begin
    state_d  = state_q;
    wait_d   = wait_q;
    bit_d    = bit_q;
    frame_d  = frame_q;
    code_d   = code_q;
    cs_n_d   = cs_n_q;
    sclk_d   = sclk_q;
    mosi_d   = mosi_q;
    w_accept = 1'b0;

    case (state_q)
      ST_STARTUP: begin
        if (int'(wait_q) == STARTUP_CYCLES - 1) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (set_pga_i) begin
          w_accept = 1'b1;
          state_d  = ST_SETUP;
          frame_d  = {CMD_BYTE, pga_code_i};
          mosi_d   = CMD_BYTE[PGA_CODE_W-1];
          cs_n_d   = 1'b0;
          bit_d    = '0;
        end
      end
      ST_SETUP: begin
        if (w_tick) begin
          state_d = ST_SHIFT;
          sclk_d  = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (w_tick) begin
          if (sclk_q) begin
            // Falling edge: present the next bit; the last bit stays on MOSI.
            sclk_d = 1'b0;
            if (bit_q != 5'd15) begin
              mosi_d = frame_q[4'd14 - bit_q[3:0]];
            end
          end else if (bit_q == 5'd15) begin
            cs_n_d  = 1'b1;
            code_d  = frame_q[PGA_CODE_W-1:0];
            wait_d  = '0;
            state_d = (SETTLE_CYCLES == 0) ? ST_IDLE : ST_SETTLE;
          end else begin
            bit_d  = bit_q + 5'd1;
            sclk_d = 1'b1;
          end
        end
      end
      ST_SETTLE: begin
        if (int'(wait_q) == SETTLE_CYCLES - 1) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_STARTUP;
        wait_d  = '0;
        cs_n_d  = 1'b1;
        sclk_d  = 1'b0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_STARTUP;
      wait_q  <= '0;
      bit_q   <= '0;
      frame_q <= '0;
      code_q  <= '0;
      ready_q <= 1'b0;
      cs_n_q  <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      bit_q   <= bit_d;
      frame_q <= frame_d;
      code_q  <= code_d;
      ready_q <= ready_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign pga_ready_o  = ready_q;
  assign pga_code_q_o = code_q;
  assign pga_cs_n_o   = cs_n_q;
  assign pga_sclk_o   = sclk_q;
  assign pga_mosi_o   = mosi_q;

endmodule
`default_nettype wire

// File: tb/tb_pga_spi_driver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pga_spi_driver : directed bench, default DUT (A) and edge DUT (B)     |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_pga_spi_driver;

  logic       clk = 1'b0;
  logic       rst_a, rst_b, set_a, set_b;
  logic [7:0] code_a, code_b, codeq_a, codeq_b;
  logic [1:0] ready_v, cs_n_v, sclk_v, mosi_v;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // per-DUT SPI monitor state, index 0 = A, 1 = B
  logic [15:0] cap        [2];
  logic [15:0] last_frame [2];
  int          bits       [2];
  int          last_bits  [2];
  int          low        [2];
  int          last_low   [2];
  int          frames     [2];
  int          fall_cyc   [2];
  int          prev_fall  [2];
  int          rise_cyc   [2];
  int          first_rise [2];
  int          rdy_rise   [2];
  logic        cs_prev    [2];
  logic        sclk_prev  [2];
  logic        rdy_prev   [2];

  always #5 clk = ~clk;

  pga_spi_driver u_dut_a (
    .clk          (clk),
    .rst          (rst_a),
    .pga_code_i   (code_a),
    .set_pga_i    (set_a),
    .pga_ready_o  (ready_v[0]),
    .pga_code_q_o (codeq_a),
    .pga_cs_n_o   (cs_n_v[0]),
    .pga_sclk_o   (sclk_v[0]),
    .pga_mosi_o   (mosi_v[0])
  );

  pga_spi_driver #(
    .CLK_DIV        (1),
    .STARTUP_CYCLES (8),
    .SETTLE_CYCLES  (0)
  ) u_dut_b (
    .clk          (clk),
    .rst          (rst_b),
    .pga_code_i   (code_b),
    .set_pga_i    (set_b),
    .pga_ready_o  (ready_v[1]),
    .pga_code_q_o (codeq_b),
    .pga_cs_n_o   (cs_n_v[1]),
    .pga_sclk_o   (sclk_v[1]),
    .pga_mosi_o   (mosi_v[1])
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance to the next negedge and update the SPI monitors.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (!cs_n_v[d]) begin
        if (cs_prev[d]) begin
          prev_fall[d] = fall_cyc[d];
          fall_cyc[d]  = cyc;
          cap[d]       = '0;
          bits[d]      = 0;
          low[d]       = 0;
        end
        low[d]++;
      end else if (!cs_prev[d]) begin
        rise_cyc[d]   = cyc;
        frames[d]++;
        last_frame[d] = cap[d];
        last_bits[d]  = bits[d];
        last_low[d]   = low[d];
      end
      if (sclk_v[d] && !sclk_prev[d]) begin
        if (bits[d] == 0) first_rise[d] = cyc;
        cap[d] = {cap[d][14:0], mosi_v[d]};
        bits[d]++;
      end
      if (ready_v[d] && !rdy_prev[d]) rdy_rise[d] = cyc;
      cs_prev[d]   = cs_n_v[d];
      sclk_prev[d] = sclk_v[d];
      rdy_prev[d]  = ready_v[d];
    end
  endtask

  task automatic wait_ready(input int d, input int budget, input string tag);
    int n = 0;
    while (!ready_v[d] && n < budget) begin
      step();
      n++;
    end
    check_value(tag, ready_v[d], 1'b1);
  endtask

  initial begin
    int n_a, first_a, first_b, viol, fr0;
    for (int d = 0; d < 2; d++) begin
      cap[d] = '0; last_frame[d] = '0; bits[d] = 0; last_bits[d] = 0;
      low[d] = 0; last_low[d] = 0; frames[d] = 0; fall_cyc[d] = 0;
      prev_fall[d] = 0; rise_cyc[d] = 0; first_rise[d] = 0; rdy_rise[d] = 0;
      cs_prev[d] = 1'b1; sclk_prev[d] = 1'b0; rdy_prev[d] = 1'b0;
    end
    rst_a = 1'b1; rst_b = 1'b1; set_a = 1'b0; set_b = 1'b0;
    code_a = 8'h00; code_b = 8'h00;
    repeat (3) step();

    check_value("rst_ready", ready_v[0], 1'b0);
    check_value("rst_cs_n",  cs_n_v[0],  1'b1);
    check_value("rst_sclk",  sclk_v[0],  1'b0);
    check_value("rst_mosi",  mosi_v[0],  1'b0);
    check_value("rst_code",  codeq_a,    8'h00);

    // Startup: the current period is cycle 0 once rst is dropped here.
    rst_a = 1'b0; rst_b = 1'b0;
    first_a = -1; first_b = -1; viol = 0;
    for (int k = 0; k < 70; k++) begin
      if (ready_v[0] && first_a < 0) first_a = k;
      if (ready_v[1] && first_b < 0) first_b = k;
      if (!cs_n_v[0] || sclk_v[0] || !cs_n_v[1] || sclk_v[1]) viol++;
      step();
    end
    check_value("su_first_ready_a", first_a, 64);
    check_value("su_first_ready_b", first_b, 8);
    check_value("su_spi_idle", viol, 0);

    // Single write on A.
    code_a = 8'hA5; set_a = 1'b1; n_a = cyc;
    step();
    set_a = 1'b0;
    check_value("sw_ready_low", ready_v[0], 1'b0);
    check_value("sw_cs_low",    cs_n_v[0],  1'b0);
    check_value("sw_mosi_msb",  mosi_v[0],  1'b0);
    check_value("sw_sclk_low",  sclk_v[0],  1'b0);
    wait_ready(0, 300, "sw_ready_wait");
    check_value("sw_frame",      last_frame[0], 16'h00A5);
    check_value("sw_bits",       last_bits[0], 16);
    check_value("sw_cs_low_len", last_low[0], 132);
    check_value("sw_cs_fall",    fall_cyc[0] - n_a, 1);
    check_value("sw_first_sclk", first_rise[0] - n_a, 5);
    check_value("sw_cs_rise",    rise_cyc[0] - n_a, 133);
    check_value("sw_ready_rise", rdy_rise[0] - n_a, 149);
    check_value("sw_code_q",     codeq_a, 8'hA5);

    // Edge parameters on B: CLK_DIV=1, no settle.
    code_b = 8'hC3; set_b = 1'b1; n_a = cyc;
    step();
    set_b = 1'b0;
    wait_ready(1, 100, "edge_ready_wait");
    check_value("edge_frame",      last_frame[1], 16'h00C3);
    check_value("edge_cs_low_len", last_low[1], 33);
    check_value("edge_first_sclk", first_rise[1] - n_a, 2);
    check_value("edge_cs_rise",    rise_cyc[1] - n_a, 34);
    check_value("edge_ready_rise", rdy_rise[1] - n_a, 34);
    check_value("edge_code_q",     codeq_b, 8'hC3);

    // Busy ignore: a second strobe mid-frame must not be queued.
    fr0 = frames[0];
    code_a = 8'h12; set_a = 1'b1; n_a = cyc;
    step();
    set_a = 1'b0;
    while (cyc < n_a + 50) step();
    code_a = 8'hFF; set_a = 1'b1;
    step();
    set_a = 1'b0;
    wait_ready(0, 300, "busy_ready_wait");
    repeat (20) step();
    check_value("busy_frames", frames[0] - fr0, 1);
    check_value("busy_frame",  last_frame[0], 16'h0012);
    check_value("busy_code_q", codeq_a, 8'h12);

    // Held strobe for 200 cycles: accepts at N and N+149 only.
    fr0 = frames[0];
    code_a = 8'h3C; set_a = 1'b1;
    repeat (200) step();
    set_a = 1'b0;
    wait_ready(0, 300, "held_ready_wait");
    repeat (20) step();
    check_value("held_frames",  frames[0] - fr0, 2);
    check_value("held_frame",   last_frame[0], 16'h003C);
    check_value("held_spacing", fall_cyc[0] - prev_fall[0], 149);

    // Reset mid-frame.
    code_a = 8'h5A; set_a = 1'b1; n_a = cyc;
    step();
    set_a = 1'b0;
    while (cyc < n_a + 40) step();
    rst_a = 1'b1;
    step();
    check_value("mid_rst_cs_n",  cs_n_v[0], 1'b1);
    check_value("mid_rst_sclk",  sclk_v[0], 1'b0);
    check_value("mid_rst_code",  codeq_a, 8'h00);
    check_value("mid_rst_ready", ready_v[0], 1'b0);
    rst_a = 1'b0;
    first_a = -1;
    for (int k = 0; k < 80; k++) begin
      if (ready_v[0] && first_a < 0) first_a = k;
      step();
    end
    check_value("mid_rst_ready_back", first_a, 64);

    // Simultaneous reset and request on B: reset wins.
    fr0 = frames[1];
    code_b = 8'h77; set_b = 1'b1; rst_b = 1'b1;
    step();
    set_b = 1'b0; rst_b = 1'b0;
    check_value("rst_set_ready", ready_v[1], 1'b0);
    repeat (5) step();
    check_value("rst_set_no_frame", frames[1] - fr0, 0);
    check_value("rst_set_cs_n", cs_n_v[1], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
